// File: rtl/symbol_upsampler.sv
// 4-ASK PRBS symbol source with UPSAMPLE-times zero-stuff or sample-and-hold
// interpolation, paced by a sample-rate strobe on the single system clock.
module symbol_upsampler #(
    parameter int          UPSAMPLE  = 4,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    input  logic               sam_clk_ena,
    input  logic               run,
    input  logic               hold_mode,
    output logic signed [17:0] x_out,
    output logic [1:0]         sym_out,
    output logic               sym_clk_ena
);

    localparam int          PH_W      = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
    localparam logic [14:0] SEED_SAFE = (LFSR_SEED == 15'h0000) ? 15'h0001 : LFSR_SEED;

    localparam logic signed [17:0] LEVEL_NEG_HI = -18'sd98304;
    localparam logic signed [17:0] LEVEL_NEG_LO = -18'sd32768;
    localparam logic signed [17:0] LEVEL_POS_LO = 18'sd32768;
    localparam logic signed [17:0] LEVEL_POS_HI = 18'sd98304;

    logic [14:0]        lfsr_q, lfsr_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic signed [17:0] xOut_q, xOut_d;
    logic [1:0]         symOut_q, symOut_d;
    logic               symClkEna_q, symClkEna_d;

    function automatic logic [14:0] lfsrStep(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // Gray-coded 4-ASK: adjacent levels differ in one bit.
    function automatic logic signed [17:0] askMap(input logic [1:0] b);
        case (b)
            2'b00:   return LEVEL_NEG_HI;
            2'b01:   return LEVEL_NEG_LO;
            2'b11:   return LEVEL_POS_LO;
            default: return LEVEL_POS_HI;
        endcase
    endfunction

    always_comb begin
        lfsr_d      = lfsr_q;
        ph_d        = ph_q;
        xOut_d      = xOut_q;
        symOut_d    = symOut_q;
        symClkEna_d = 1'b0;
        if (sam_clk_ena) begin
            if (!run) begin
                // Idle flushes the filter input and re-aligns to a symbol boundary.
                xOut_d = '0;
                ph_d   = '0;
            end else begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == '0) begin
                    xOut_d      = askMap(lfsr_q[1:0]);
                    symOut_d    = lfsr_q[1:0];
                    lfsr_d      = (lfsr_q == '0) ? 15'h0001 : lfsrStep(lfsrStep(lfsr_q));
                    symClkEna_d = 1'b1;
                end else if (!hold_mode) begin
                    xOut_d = '0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            lfsr_q      <= SEED_SAFE;
            ph_q        <= '0;
            xOut_q      <= '0;
            symOut_q    <= 2'b00;
            symClkEna_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            ph_q        <= ph_d;
            xOut_q      <= xOut_d;
            symOut_q    <= symOut_d;
            symClkEna_q <= symClkEna_d;
        end
    end

    assign x_out       = xOut_q;
    assign sym_out     = symOut_q;
    assign sym_clk_ena = symClkEna_q;

endmodule

// File: tb/tb_symbol_upsampler.sv
// Self-checking bench for symbol_upsampler: bit-stream PRBS reference model
// compared every cycle, plus directed literal checks.
module tb_symbol_upsampler;

    localparam int UP       = 4;
    localparam int PERIOD   = 32767;
    localparam int NBITS    = 4 * PERIOD + 32;

    localparam int EXP_X_ZS[9]  = '{-32768, 0, 0, 0, -98304, 0, 0, 0, -98304};
    localparam int EXP_E_ZS[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    localparam int EXP_X_SH[8]  = '{-32768, -32768, -32768, -32768, -98304, -98304, -98304, -98304};
    localparam int EXP_S_SH[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};

    logic               sys_clk;
    logic               reset_n;
    logic               sam_clk_ena;
    logic               run;
    logic               hold_mode;
    logic signed [17:0] x_out, x_out_z;
    logic [1:0]         sym_out, sym_out_z;
    logic               sym_clk_ena, sym_clk_ena_z;

    int  totalCount = 0;
    int  badCount   = 0;
    int  failPrints = 0;
    bit  modelValid = 0;
    bit  bits[NBITS];

    int  expX   = 0;
    int  expSym = 0;
    int  expEna = 0;
    int  symIdx = 0;
    int  phase  = 0;

    symbol_upsampler #(.UPSAMPLE(UP), .LFSR_SEED(15'h0001)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sam_clk_ena(sam_clk_ena),
        .run        (run),
        .hold_mode  (hold_mode),
        .x_out      (x_out),
        .sym_out    (sym_out),
        .sym_clk_ena(sym_clk_ena)
    );

    // A zero seed must behave exactly like seed 1.
    symbol_upsampler #(.UPSAMPLE(UP), .LFSR_SEED(15'h0000)) dutZero (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sam_clk_ena(sam_clk_ena),
        .run        (run),
        .hold_mode  (hold_mode),
        .x_out      (x_out_z),
        .sym_out    (sym_out_z),
        .sym_clk_ena(sym_clk_ena_z)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Symbol k is the pair of stream bits present in lfsr[1:0] after 2k shifts.
    function automatic int prbsSym(input int k);
        return {bits[2*k+13], bits[2*k+14]};
    endfunction

    function automatic int levelOf(input int s);
        case (s)
            0:       return -98304;
            1:       return -32768;
            3:       return 32768;
            default: return 98304;
        endcase
    endfunction

    function automatic bit legalLevel(input int v);
        return (v == 0) || (v == 32768) || (v == -32768) || (v == 98304) || (v == -98304);
    endfunction

    // Reference: integer symbol index and phase within the symbol.
    always @(posedge sys_clk) begin
        if (!reset_n) begin
            symIdx = 0; phase = 0; expX = 0; expSym = 0; expEna = 0;
        end else begin
            expEna = 0;
            if (sam_clk_ena) begin
                if (!run) begin
                    expX  = 0;
                    phase = 0;
                end else begin
                    if (phase == 0) begin
                        expSym = prbsSym(symIdx % PERIOD);
                        expX   = levelOf(expSym);
                        expEna = 1;
                        symIdx++;
                    end else if (!hold_mode) begin
                        expX = 0;
                    end
                    phase = (phase + 1) % UP;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        int xa, xz;
        if (modelValid) begin
            xa = x_out;
            xz = x_out_z;
            totalCount++;
            if (xa != expX || int'(sym_out) != expSym || int'(sym_clk_ena) != expEna) begin
                badCount++;
                if (failPrints < 20) begin
                    failPrints++;
                    $display("[TB] FAIL model_cmp t=%0t x=%0d want %0d sym=%0d want %0d ena=%0d want %0d",
                             $time, xa, expX, sym_out, expSym, sym_clk_ena, expEna);
                end
            end
            totalCount++;
            if (xz != expX || int'(sym_out_z) != expSym || int'(sym_clk_ena_z) != expEna) begin
                badCount++;
                if (failPrints < 20) begin
                    failPrints++;
                    $display("[TB] FAIL seed0_cmp t=%0t x=%0d want %0d sym=%0d want %0d ena=%0d want %0d",
                             $time, xz, expX, sym_out_z, expSym, sym_clk_ena_z, expEna);
                end
            end
            totalCount++;
            if (!legalLevel(xa)) begin
                badCount++;
                if (failPrints < 20) begin
                    failPrints++;
                    $display("[TB] FAIL level_legal t=%0t x=%0d not a legal level", $time, xa);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rstN, input logic runV, input logic holdV, input logic enaV);
        reset_n     = rstN;
        run         = runV;
        hold_mode   = holdV;
        sam_clk_ena = enaV;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCount++;
        if (actual != expected) begin
            badCount++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int mism, pulses, doubles, prevEna;
        reset_n = 1'b0; run = 1'b0; hold_mode = 1'b0; sam_clk_ena = 1'b0;

        for (int i = 0; i < 14; i++) bits[i] = 1'b0;
        bits[14] = 1'b1;
        for (int i = 15; i < NBITS; i++) bits[i] = bits[i-14] ^ bits[i-15];

        checkOutput("model_sym0", prbsSym(0), 1);
        checkOutput("model_sym1", prbsSym(1), 0);
        checkOutput("model_sym7", prbsSym(7), 1);
        checkOutput("model_sym8", prbsSym(8), 2);
        mism = 0;
        for (int k = 0; k < PERIOD; k++) if (prbsSym(k) != prbsSym(k + PERIOD)) mism++;
        checkOutput("prbs_period", mism, 0);

        doReset();
        modelValid = 1;
        checkOutput("reset_x", int'(x_out), 0);
        checkOutput("reset_sym", int'(sym_out), 0);
        checkOutput("reset_ena", int'(sym_clk_ena), 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("zs_x%0d", i), int'(x_out), EXP_X_ZS[i]);
            checkOutput($sformatf("zs_ena%0d", i), int'(sym_clk_ena), EXP_E_ZS[i]);
        end

        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput($sformatf("sh_x%0d", i), int'(x_out), EXP_X_SH[i]);
            checkOutput($sformatf("sh_sym%0d", i), int'(sym_out), EXP_S_SH[i]);
        end

        doReset();
        pulses = 0; doubles = 0; prevEna = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, (i % 4) == 0);
            if (sym_clk_ena) pulses++;
            if (sym_clk_ena && prevEna == 1) doubles++;
            prevEna = int'(sym_clk_ena);
        end
        checkOutput("rate4_pulses", pulses, 4);
        checkOutput("rate4_width", doubles, 0);

        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("idle_x%0d", i), int'(x_out), 0);
            checkOutput($sformatf("idle_ena%0d", i), int'(sym_clk_ena), 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("resume_x", int'(x_out), -98304);
        checkOutput("resume_sym", int'(sym_out), 0);
        checkOutput("resume_ena", int'(sym_clk_ena), 1);

        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_x", int'(x_out), 0);
        checkOutput("midrst_sym", int'(sym_out), 0);
        checkOutput("midrst_ena", int'(sym_clk_ena), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("restart_x", int'(x_out), -32768);
        checkOutput("restart_sym", int'(sym_out), 1);
        checkOutput("restart_ena", int'(sym_clk_ena), 1);

        doReset();
        for (int i = 0; i < 16000; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4000; i++)
            applyStimulus(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1);

        modelValid = 0;
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
